// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT decryption key unroller: widths, S-box tables, FSM states.
package present_pkg;

  localparam int KEY_SIZE_80  = 80;
  localparam int KEY_SIZE_128 = 128;
  localparam int RK_WIDTH     = 64;
  localparam int CNT_WIDTH    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2
  } state_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/present_key_unroller_if.sv
// Key-load and round-key handshake bundle between the key source, the unroller and the round core.
interface present_key_unroller_if #(
  parameter int KEY_SIZE = 80
) ();
  import present_pkg::*;

  logic                  load_valid;
  logic                  load_ready;
  logic [KEY_SIZE-1:0]   key_in;
  logic                  flush;
  logic                  rk_valid;
  logic                  rk_ready;
  logic [RK_WIDTH-1:0]   rk_out;
  logic [CNT_WIDTH-1:0]  rk_round;
  logic                  rk_last;

  modport master (
    output load_valid, key_in, flush, rk_ready,
    input  load_ready, rk_valid, rk_out, rk_round, rk_last
  );

  modport slave (
    input  load_valid, key_in, flush, rk_ready,
    output load_ready, rk_valid, rk_out, rk_round, rk_last
  );
endinterface

// File: rtl/present_key_unroller_step.sv
// One PRESENT key-schedule update, forward (dir=0) or its exact inverse (dir=1).
module present_key_step
  import present_pkg::*;
#(
  parameter int KEY_SIZE = 80
) (
  input  logic                 dir,
  input  logic [KEY_SIZE-1:0]  key,
  input  logic [CNT_WIDTH-1:0] cnt,
  output logic [KEY_SIZE-1:0]  key_out
);

  // The round counter lands at a different bit position for the two key sizes.
  localparam int CNT_LSB = (KEY_SIZE == KEY_SIZE_128) ? 62 : 15;

  logic [KEY_SIZE-1:0] fwd_key;
  logic [KEY_SIZE-1:0] inv_tmp;
  logic [KEY_SIZE-1:0] inv_key;

  always_comb begin
    fwd_key = {key[KEY_SIZE-62:0], key[KEY_SIZE-1:KEY_SIZE-61]};
    fwd_key[KEY_SIZE-1 -: 4] = sbox(fwd_key[KEY_SIZE-1 -: 4]);
    if (KEY_SIZE == KEY_SIZE_128) begin
      fwd_key[KEY_SIZE-5 -: 4] = sbox(fwd_key[KEY_SIZE-5 -: 4]);
    end
    fwd_key[CNT_LSB +: CNT_WIDTH] = fwd_key[CNT_LSB +: CNT_WIDTH] ^ cnt;

    // Undo the forward steps in reverse order: counter, S-box, then rotate right 61.
    inv_tmp = key;
    inv_tmp[CNT_LSB +: CNT_WIDTH] = inv_tmp[CNT_LSB +: CNT_WIDTH] ^ cnt;
    inv_tmp[KEY_SIZE-1 -: 4] = inv_sbox(inv_tmp[KEY_SIZE-1 -: 4]);
    if (KEY_SIZE == KEY_SIZE_128) begin
      inv_tmp[KEY_SIZE-5 -: 4] = inv_sbox(inv_tmp[KEY_SIZE-5 -: 4]);
    end
    inv_key = {inv_tmp[60:0], inv_tmp[KEY_SIZE-1:61]};

    key_out = dir ? inv_key : fwd_key;
  end

endmodule

// File: rtl/present_key_unroller.sv
// Expands a master key forward to the final round key, then walks back emitting keys last-to-first.
module present_key_unroller
  import present_pkg::*;
#(
  parameter int KEY_SIZE   = 80,
  parameter int NUM_ROUNDS = 31
) (
  input logic                   clk,
  input logic                   rst_n,
  present_key_unroller_if.slave bus
);

  if (!(KEY_SIZE == KEY_SIZE_80 || KEY_SIZE == KEY_SIZE_128)) begin : g_bad_key_size
    $error("present_key_unroller: KEY_SIZE must be 80 or 128");
  end
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_num_rounds
    $error("present_key_unroller: NUM_ROUNDS must be 1..31");
  end

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_ROUNDS);

  state_e                state_q, state_d;
  logic [KEY_SIZE-1:0]   key_reg_q, key_reg_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  load_ready_q, load_ready_d;
  logic                  rk_valid_q, rk_valid_d;
  logic [CNT_WIDTH-1:0]  rk_round_q, rk_round_d;
  logic                  rk_last_q, rk_last_d;
  logic [KEY_SIZE-1:0]   step_key;

  present_key_step #(
    .KEY_SIZE (KEY_SIZE)
  ) u_step (
    .dir     (state_q == REV),
    .key     (key_reg_q),
    .cnt     (cnt_q),
    .key_out (step_key)
  );

  always_comb begin
    state_d   = state_q;
    key_reg_d = key_reg_q;
    cnt_d     = cnt_q;

    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.load_valid) begin
            key_reg_d = bus.key_in;
            cnt_d     = 5'd1;
            state_d   = FWD;
          end
        end
        FWD: begin
          key_reg_d = step_key;
          if (cnt_q == LAST_CNT) begin
            state_d = REV;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        REV: begin
          if (rk_valid_q && bus.rk_ready) begin
            if (cnt_q != 5'd0) begin
              key_reg_d = step_key;
              cnt_d     = cnt_q - 5'd1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are decoded from next state so they leave the flops aligned with it.
    // rk_round is 5 bits wide, so index 32 shows up as 0.
    load_ready_d = (state_d == IDLE);
    rk_valid_d   = (state_d == REV);
    rk_round_d   = rk_valid_d ? cnt_d + 5'd1 : 5'd0;
    rk_last_d    = rk_valid_d && (cnt_d == 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      key_reg_q    <= '0;
      cnt_q        <= '0;
      load_ready_q <= 1'b1;
      rk_valid_q   <= 1'b0;
      rk_round_q   <= '0;
      rk_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_reg_q    <= key_reg_d;
      cnt_q        <= cnt_d;
      load_ready_q <= load_ready_d;
      rk_valid_q   <= rk_valid_d;
      rk_round_q   <= rk_round_d;
      rk_last_q    <= rk_last_d;
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.rk_valid   = rk_valid_q;
  assign bus.rk_out     = key_reg_q[KEY_SIZE-1 -: RK_WIDTH];
  assign bus.rk_round   = rk_round_q;
  assign bus.rk_last    = rk_last_q;

endmodule

// File: tb/tb_present_key_unroller.sv
// Directed bench for present_key_unroller: 80-bit and 128-bit instances against a forward-only key model.
module tb_present_key_unroller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  present_key_unroller_if #(.KEY_SIZE(80))  bus80 ();
  present_key_unroller_if #(.KEY_SIZE(128)) bus128 ();

  present_key_unroller #(.KEY_SIZE(80), .NUM_ROUNDS(31)) dut80 (
    .clk (clk), .rst_n (rst_n), .bus (bus80)
  );
  present_key_unroller #(.KEY_SIZE(128), .NUM_ROUNDS(31)) dut128 (
    .clk (clk), .rst_n (rst_n), .bus (bus128)
  );

  always #5 clk = ~clk;

  logic [63:0] kexp [1:32];
  logic [63:0] obs_key [32];
  logic [4:0]  obs_round [32];
  logic        obs_last [32];
  logic        obs_valid [32];
  int          lat;
  int          ready_hi;
  bit          load_to;

  localparam logic [79:0] ONES80 = {80{1'b1}};

  function automatic logic [3:0] m_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Reference forward key update; the reverse walk of the DUT is checked against stored forward keys.
  function automatic logic [127:0] m_fwd(input bit w128, input logic [127:0] k, input logic [4:0] c);
    logic [127:0] r;
    r = '0;
    if (w128) begin
      r = {k[66:0], k[127:67]};
      r[127:124] = m_sbox(r[127:124]);
      r[123:120] = m_sbox(r[123:120]);
      r[66:62]   = r[66:62] ^ c;
    end else begin
      r[79:0]  = {k[18:0], k[79:19]};
      r[79:76] = m_sbox(r[79:76]);
      r[19:15] = r[19:15] ^ c;
    end
    return r;
  endfunction

  task automatic build(input bit w128, input logic [127:0] key);
    logic [127:0] st;
    st = key;
    for (int r = 1; r <= 32; r++) begin
      kexp[r] = w128 ? st[127:64] : st[79:16];
      if (r < 32) st = m_fwd(w128, st, 5'(r));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a key, waits for acceptance, then counts cycles until the first round key appears.
  task automatic load(input bit w128, input logic [127:0] key);
    int n;
    load_to = 1'b0;
    lat = 0;
    ready_hi = 0;
    n = 0;
    if (w128) begin
      bus128.key_in = key;
      bus128.load_valid = 1'b1;
    end else begin
      bus80.key_in = key[79:0];
      bus80.load_valid = 1'b1;
    end
    while (!(w128 ? bus128.load_ready : bus80.load_ready) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) load_to = 1'b1;
    tick();
    bus80.load_valid = 1'b0;
    bus128.load_valid = 1'b0;
    while (!(w128 ? bus128.rk_valid : bus80.rk_valid) && lat < 100) begin
      if (w128 ? bus128.load_ready : bus80.load_ready) ready_hi++;
      tick();
      lat++;
    end
  endtask

  // Records 32 consecutive round keys with rk_ready held high; optionally pokes load_valid mid-stream.
  task automatic drain(input bit w128, input int inject_at);
    if (w128) bus128.rk_ready = 1'b1;
    else      bus80.rk_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      obs_key[i]   = w128 ? bus128.rk_out   : bus80.rk_out;
      obs_round[i] = w128 ? bus128.rk_round : bus80.rk_round;
      obs_last[i]  = w128 ? bus128.rk_last  : bus80.rk_last;
      obs_valid[i] = w128 ? bus128.rk_valid : bus80.rk_valid;
      if (i == inject_at) begin
        bus128.key_in = {128{1'b1}};
        bus128.load_valid = 1'b1;
      end
      if (i == inject_at + 3) bus128.load_valid = 1'b0;
      tick();
    end
    bus128.load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus80.load_ready, bus80.rk_valid, bus80.rk_out, bus80.rk_round, bus80.rk_last} !== {1'b1, 1'b0, 64'h0, 5'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset80: got ready=%b valid=%b out=%h round=%0d last=%b, want 1 0 0 0 0",
               bus80.load_ready, bus80.rk_valid, bus80.rk_out, bus80.rk_round, bus80.rk_last);
    end
    checks++;
    if ({bus128.load_ready, bus128.rk_valid, bus128.rk_out, bus128.rk_round, bus128.rk_last} !== {1'b1, 1'b0, 64'h0, 5'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset128: got ready=%b valid=%b out=%h round=%0d last=%b, want 1 0 0 0 0",
               bus128.load_ready, bus128.rk_valid, bus128.rk_out, bus128.rk_round, bus128.rk_last);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_key();
    build(1'b0, '0);
    load(1'b0, '0);
    checks++;
    if (load_to || lat != 31 || ready_hi != 0) begin
      errors++;
      $display("[TB] FAIL zero80_latency: got lat=%0d ready_high_cycles=%0d timeout=%b, want 31 0 0", lat, ready_hi, load_to);
    end
    drain(1'b0, -1);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (obs_key[i] !== kexp[32-i] || obs_round[i] !== 5'(32 - i) || obs_last[i] !== (i == 31) || obs_valid[i] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL zero80_seq[%0d]: got key=%h round=%0d last=%b valid=%b, want key=%h round=%0d last=%b valid=1",
                 i, obs_key[i], obs_round[i], obs_last[i], obs_valid[i], kexp[32-i], 5'(32 - i), (i == 31));
      end
    end
    checks++;
    if (obs_key[30] !== 64'hC000000000000000 || obs_round[30] !== 5'd2 || obs_key[31] !== 64'h0 || obs_last[31] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero80_tail: got k2=%h r2=%0d k1=%h last=%b, want C000000000000000 2 0000000000000000 1",
               obs_key[30], obs_round[30], obs_key[31], obs_last[31]);
    end
    checks++;
    if ({bus80.load_ready, bus80.rk_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL zero80_idle: got ready=%b valid=%b, want 1 0", bus80.load_ready, bus80.rk_valid);
    end
  endtask

  task automatic test_ones_key();
    build(1'b0, {48'h0, ONES80});
    load(1'b0, {48'h0, ONES80});
    checks++;
    if (load_to || lat != 31) begin
      errors++;
      $display("[TB] FAIL ones80_latency: got lat=%0d timeout=%b, want 31 0", lat, load_to);
    end
    drain(1'b0, -1);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (obs_key[i] !== kexp[32-i] || obs_round[i] !== 5'(32 - i) || obs_last[i] !== (i == 31)) begin
        errors++;
        $display("[TB] FAIL ones80_seq[%0d]: got key=%h round=%0d last=%b, want key=%h round=%0d last=%b",
                 i, obs_key[i], obs_round[i], obs_last[i], kexp[32-i], 5'(32 - i), (i == 31));
      end
    end
    checks++;
    if (obs_key[31] !== 64'hFFFFFFFFFFFFFFFF) begin
      errors++;
      $display("[TB] FAIL ones80_k1: got %h, want FFFFFFFFFFFFFFFF", obs_key[31]);
    end
  endtask

  task automatic test_backpressure();
    logic [79:0] key;
    logic [63:0] seq [32];
    logic [4:0]  seq_round [32];
    logic [63:0] pk;
    logic [4:0]  prd;
    logic        pv, pr, pl;
    int          hs, n;
    key = 80'h0123456789ABCDEF0123;
    build(1'b0, {48'h0, key});
    load(1'b0, {48'h0, key});
    checks++;
    if (load_to || lat != 31) begin
      errors++;
      $display("[TB] FAIL bp_latency: got lat=%0d timeout=%b, want 31 0", lat, load_to);
    end
    hs = 0;
    n = 0;
    while (hs < 32 && n < 1000) begin
      bus80.rk_ready = (n % 4 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      pv = bus80.rk_valid; pr = bus80.rk_ready; pk = bus80.rk_out; prd = bus80.rk_round; pl = bus80.rk_last;
      if (pv && pr) begin
        seq[hs] = pk;
        seq_round[hs] = prd;
        hs++;
      end
      tick();
      n++;
      if (pv && !pr) begin
        checks++;
        if ({bus80.rk_valid, bus80.rk_out, bus80.rk_round, bus80.rk_last} !== {1'b1, pk, prd, pl}) begin
          errors++;
          $display("[TB] FAIL bp_stable: got valid=%b out=%h round=%0d last=%b, want 1 %h %0d %b",
                   bus80.rk_valid, bus80.rk_out, bus80.rk_round, bus80.rk_last, pk, prd, pl);
        end
      end
    end
    bus80.rk_ready = 1'b1;
    checks++;
    if (hs != 32 || bus80.rk_valid !== 1'b0 || bus80.load_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_count: got handshakes=%0d valid=%b ready=%b, want 32 0 1", hs, bus80.rk_valid, bus80.load_ready);
    end
    for (int j = 0; j < 32; j++) begin
      if (j < hs) begin
        checks++;
        if (seq[j] !== kexp[32-j] || seq_round[j] !== 5'(32 - j)) begin
          errors++;
          $display("[TB] FAIL bp_seq[%0d]: got key=%h round=%0d, want key=%h round=%0d",
                   j, seq[j], seq_round[j], kexp[32-j], 5'(32 - j));
        end
      end
    end
  endtask

  task automatic test_flush_fwd();
    build(1'b0, '0);
    bus80.key_in = '0;
    bus80.load_valid = 1'b1;
    tick();
    bus80.load_valid = 1'b0;
    repeat (9) tick();
    bus80.flush = 1'b1;
    tick();
    bus80.flush = 1'b0;
    checks++;
    if ({bus80.rk_valid, bus80.load_ready} !== 2'b01 || bus80.rk_out !== kexp[10]) begin
      errors++;
      $display("[TB] FAIL flush_fwd: got valid=%b ready=%b out=%h, want 0 1 %h",
               bus80.rk_valid, bus80.load_ready, bus80.rk_out, kexp[10]);
    end
    load(1'b0, '0);
    drain(1'b0, -1);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (obs_key[i] !== kexp[32-i] || obs_round[i] !== 5'(32 - i) || obs_last[i] !== (i == 31)) begin
        errors++;
        $display("[TB] FAIL flush_fwd_reload[%0d]: got key=%h round=%0d last=%b, want key=%h round=%0d last=%b",
                 i, obs_key[i], obs_round[i], obs_last[i], kexp[32-i], 5'(32 - i), (i == 31));
      end
    end
  endtask

  task automatic test_flush_rev();
    build(1'b0, '0);
    load(1'b0, '0);
    bus80.rk_ready = 1'b1;
    repeat (12) tick();
    checks++;
    if (bus80.rk_round !== 5'd20 || bus80.rk_out !== kexp[20]) begin
      errors++;
      $display("[TB] FAIL flush_rev_pos: got round=%0d out=%h, want 20 %h", bus80.rk_round, bus80.rk_out, kexp[20]);
    end
    bus80.flush = 1'b1;
    tick();
    bus80.flush = 1'b0;
    checks++;
    if ({bus80.rk_valid, bus80.load_ready} !== 2'b01 || bus80.rk_out !== kexp[20]) begin
      errors++;
      $display("[TB] FAIL flush_rev: got valid=%b ready=%b out=%h, want 0 1 %h",
               bus80.rk_valid, bus80.load_ready, bus80.rk_out, kexp[20]);
    end
    load(1'b0, '0);
    drain(1'b0, -1);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (obs_key[i] !== kexp[32-i] || obs_round[i] !== 5'(32 - i) || obs_last[i] !== (i == 31)) begin
        errors++;
        $display("[TB] FAIL flush_rev_reload[%0d]: got key=%h round=%0d last=%b, want key=%h round=%0d last=%b",
                 i, obs_key[i], obs_round[i], obs_last[i], kexp[32-i], 5'(32 - i), (i == 31));
      end
    end
  endtask

  task automatic test_async_reset();
    load(1'b0, {48'h0, ONES80});
    bus80.rk_ready = 1'b1;
    repeat (5) tick();
    bus80.rk_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus80.load_ready, bus80.rk_valid, bus80.rk_out, bus80.rk_round, bus80.rk_last} !== {1'b1, 1'b0, 64'h0, 5'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL async_reset: got ready=%b valid=%b out=%h round=%0d last=%b, want 1 0 0 0 0",
               bus80.load_ready, bus80.rk_valid, bus80.rk_out, bus80.rk_round, bus80.rk_last);
    end
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bus80.load_ready, bus80.rk_valid, bus80.rk_out} !== {1'b1, 1'b0, 64'h0}) begin
      errors++;
      $display("[TB] FAIL async_reset_after: got ready=%b valid=%b out=%h, want 1 0 0",
               bus80.load_ready, bus80.rk_valid, bus80.rk_out);
    end
    bus80.rk_ready = 1'b1;
  endtask

  task automatic test_key128();
    build(1'b1, '0);
    load(1'b1, '0);
    checks++;
    if (load_to || lat != 31 || ready_hi != 0) begin
      errors++;
      $display("[TB] FAIL k128_latency: got lat=%0d ready_high_cycles=%0d timeout=%b, want 31 0 0", lat, ready_hi, load_to);
    end
    drain(1'b1, 5);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (obs_key[i] !== kexp[32-i] || obs_round[i] !== 5'(32 - i) || obs_last[i] !== (i == 31) || obs_valid[i] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL k128_seq[%0d]: got key=%h round=%0d last=%b valid=%b, want key=%h round=%0d last=%b valid=1",
                 i, obs_key[i], obs_round[i], obs_last[i], obs_valid[i], kexp[32-i], 5'(32 - i), (i == 31));
      end
    end
    // Both top nibbles pass through the S-box on the first 128-bit update, giving CC in K2.
    checks++;
    if (obs_key[30] !== 64'hCC00000000000000 || obs_round[30] !== 5'd2 || obs_key[31] !== 64'h0 ||
        obs_round[31] !== 5'd1 || obs_last[31] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL k128_tail: got k2=%h r2=%0d k1=%h r1=%0d last=%b, want CC00000000000000 2 0000000000000000 1 1",
               obs_key[30], obs_round[30], obs_key[31], obs_round[31], obs_last[31]);
    end
    checks++;
    if ({bus128.load_ready, bus128.rk_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL k128_idle: got ready=%b valid=%b, want 1 0", bus128.load_ready, bus128.rk_valid);
    end
  endtask

  initial begin
    bus80.load_valid = 1'b0;  bus80.key_in = '0;  bus80.flush = 1'b0;  bus80.rk_ready = 1'b0;
    bus128.load_valid = 1'b0; bus128.key_in = '0; bus128.flush = 1'b0; bus128.rk_ready = 1'b0;
    test_reset();
    test_zero_key();
    test_ones_key();
    test_backpressure();
    test_flush_fwd();
    test_flush_rev();
    test_async_reset();
    test_key128();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
